// File: rtl/id_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : id_dispatch
//  Description : Dispatch stage behind the instruction-decode queue. Pops the
//                queue head when ROB/LSQ credits and the output slot allow,
//                stamps an in-order ROB tag and holds the instruction in a
//                registered valid/ready slot toward the issue queue.
//                Optional build macro ID_DISPATCH_STATS_EN adds three
//                saturating stall-cause counters (stall_rob/stall_lsq/stall_iq).
//  Revision    : 1.0 - initial release
// ============================================================================
module id_dispatch #(
    parameter int ROB_PTR  = 4,
    parameter int LSQ_SIZE = 8,
    parameter int ENTRY_W  = 96
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      FREEZE,
    input  logic                      mispredict,
    input  logic                      flush_fCOM,
    input  logic                      idq_empty,
    input  logic [ENTRY_W-1:0]        idq_data,
    output logic                      idq_read,
    output logic                      disp_valid,
    output logic [ENTRY_W-1:0]        disp_data,
    output logic [ROB_PTR-1:0]        disp_tag,
    input  logic                      disp_ready,
    input  logic                      rob_release,
    input  logic                      lsq_release,
    output logic [ROB_PTR:0]          rob_credits,
    output logic [$clog2(LSQ_SIZE):0] lsq_credits
`ifdef ID_DISPATCH_STATS_EN
    ,
    output logic [31:0]               stall_rob,
    output logic [31:0]               stall_lsq,
    output logic [31:0]               stall_iq
`endif
);

    localparam int                LSQ_CW     = $clog2(LSQ_SIZE) + 1;
    localparam logic [ROB_PTR:0]  C_ROB_FULL = {1'b1, {ROB_PTR{1'b0}}};
    localparam logic [ROB_PTR:0]  C_ROB_ONE  = (ROB_PTR+1)'(1);
    localparam logic [LSQ_CW-1:0] C_LSQ_FULL = LSQ_CW'(LSQ_SIZE);
    localparam logic [LSQ_CW-1:0] C_LSQ_ONE  = LSQ_CW'(1);
    localparam logic [ROB_PTR-1:0] C_TAG_ONE = ROB_PTR'(1);

    // Bit 70 marks a memory op; bit 11 (writes-register) only rides along.
    localparam int C_MEM_BIT = 70;

    logic                r_disp_valid;
    logic [ENTRY_W-1:0]  r_disp_data;
    logic [ROB_PTR-1:0]  r_disp_tag;
    logic [ROB_PTR-1:0]  r_next_tag;
    logic [ROB_PTR:0]    r_rob_credits;
    logic [LSQ_CW-1:0]   r_lsq_credits;

    logic w_flush;
    logic w_slot_free;
    logic w_is_mem;
    logic w_rob_ok;
    logic w_lsq_ok;
    logic w_pop;
    logic w_lsq_take;

    assign w_flush     = mispredict | flush_fCOM;
    assign w_slot_free = !r_disp_valid || disp_ready;
    assign w_is_mem    = idq_data[C_MEM_BIT];
    assign w_rob_ok    = (r_rob_credits != '0);
    assign w_lsq_ok    = !w_is_mem || (r_lsq_credits != '0);
    assign w_pop       = !FREEZE && !w_flush && !idq_empty && w_slot_free
                         && w_rob_ok && w_lsq_ok;
    assign w_lsq_take  = w_pop && w_is_mem;

    // Pop strobe is forced low while reset is held so the queue never drains.
    assign idq_read    = w_pop && RESET;
    assign disp_valid  = r_disp_valid;
    assign disp_data   = r_disp_data;
    assign disp_tag    = r_disp_tag;
    assign rob_credits = r_rob_credits;
    assign lsq_credits = r_lsq_credits;

    // Output slot and in-order tag counter: load on pop, drain on accept.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_disp_valid <= 1'b0;
            r_disp_data  <= '0;
            r_disp_tag   <= '0;
            r_next_tag   <= '0;
        end else if (w_flush) begin
            r_disp_valid <= 1'b0;
            r_next_tag   <= '0;
        end else if (!FREEZE) begin
            if (w_pop) begin
                r_disp_valid <= 1'b1;
                r_disp_data  <= idq_data;
                r_disp_tag   <= r_next_tag;
                r_next_tag   <= r_next_tag + C_TAG_ONE;
            end else if (disp_ready) begin
                r_disp_valid <= 1'b0;
            end
        end
    end

    // ROB credits: pop consumes, release returns; saturate at full.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_rob_credits <= C_ROB_FULL;
        end else if (w_flush) begin
            r_rob_credits <= C_ROB_FULL;
        end else if (!FREEZE) begin
            case ({w_pop, rob_release})
                2'b10:   r_rob_credits <= r_rob_credits - C_ROB_ONE;
                2'b01:   if (r_rob_credits != C_ROB_FULL)
                             r_rob_credits <= r_rob_credits + C_ROB_ONE;
                default: r_rob_credits <= r_rob_credits;
            endcase
        end
    end

    // LSQ credits: only memory ops consume; saturate at capacity.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_lsq_credits <= C_LSQ_FULL;
        end else if (w_flush) begin
            r_lsq_credits <= C_LSQ_FULL;
        end else if (!FREEZE) begin
            case ({w_lsq_take, lsq_release})
                2'b10:   r_lsq_credits <= r_lsq_credits - C_LSQ_ONE;
                2'b01:   if (r_lsq_credits != C_LSQ_FULL)
                             r_lsq_credits <= r_lsq_credits + C_LSQ_ONE;
                default: r_lsq_credits <= r_lsq_credits;
            endcase
        end
    end

`ifdef ID_DISPATCH_STATS_EN
    logic        w_stat_en;
    logic [31:0] r_stall_rob;
    logic [31:0] r_stall_lsq;
    logic [31:0] r_stall_iq;

    assign w_stat_en = !idq_empty && !w_flush && !FREEZE;
    assign stall_rob = r_stall_rob;
    assign stall_lsq = r_stall_lsq;
    assign stall_iq  = r_stall_iq;

    // Attribute each blocked cycle to its first cause only; flush leaves counts.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_stall_rob <= '0;
            r_stall_lsq <= '0;
            r_stall_iq  <= '0;
        end else if (w_stat_en) begin
            if (!w_rob_ok) begin
                if (r_stall_rob != '1) r_stall_rob <= r_stall_rob + 32'd1;
            end else if (!w_lsq_ok) begin
                if (r_stall_lsq != '1) r_stall_lsq <= r_stall_lsq + 32'd1;
            end else if (!w_slot_free) begin
                if (r_stall_iq != '1)  r_stall_iq  <= r_stall_iq + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
